regfile_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer that shares one 8x8 register file between N_REQ requesters.

---
 rtl/regfile_arbiter_if.sv | 35 +++
 rtl/regfile_arbiter.sv | 143 ++++++++++++++
 tb/tb_regfile_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_arbiter_if.sv
// Bundle of requester handshake signals and register-file bus signals
// that surround regfile_arbiter. The master view belongs to the arbiter.
// The slave view belongs to its environment: the clients and the register file.
interface regfile_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int AW    = 3,
  parameter int DW    = 8
);
  // requester side
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    req_wr;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_wdata;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    rvalid;
  logic [DW-1:0]       rdata;
  logic                busy;

  // register-file side
  logic                rf_wen;
  logic                rf_oen;
  logic [AW-1:0]       rf_addr;
  logic [DW-1:0]       rf_din;
  logic [DW-1:0]       rf_dout;

  modport master (
    input  req, req_wr, req_addr, req_wdata, rf_dout,
    output gnt, rvalid, rdata, busy, rf_wen, rf_oen, rf_addr, rf_din
  );

  modport slave (
    output req, req_wr, req_addr, req_wdata, rf_dout,
    input  gnt, rvalid, rdata, busy, rf_wen, rf_oen, rf_addr, rf_din
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Round-robin sequencer that shares one register file between N_REQ clients.
// Only one operation is in flight at a time:
//   - a write takes ISSUE and then returns to IDLE;
//   - a read takes ISSUE, then RD_WAIT, then returns data.
// Every output is a flop, so no combinational path exists from the request inputs to any output.
module regfile_arbiter #(
  parameter int N_REQ = 2,
  parameter int AW    = 3,
  parameter int DW    = 8
) (
  input logic               clk,
  input logic               rst_n,
  regfile_arbiter_if.master bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  state_t         state;
  state_t         next_state;

  logic [IW-1:0]  last;
  logic [IW-1:0]  win;
  logic           any_req;
  logic           accept;
  logic [IW-1:0]  op_win;
  logic           op_wr;

  logic [N_REQ-1:0] gnt_d;
  logic [N_REQ-1:0] rvalid_d;
  logic [DW-1:0]    rdata_d;
  logic             busy_d;
  logic             rf_wen_d;
  logic             rf_oen_d;
  logic [AW-1:0]    rf_addr_d;
  logic [DW-1:0]    rf_din_d;

  // Round-robin pick: the first requesting client after the last winner.
  always_comb begin : pick_winner
    logic [IW-1:0] idx;
    idx     = '0;
    win     = '0;
    any_req = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IW'((int'(last) + k) % N_REQ);
      if (!any_req && bus.req[idx]) begin
        any_req = 1'b1;
        win     = idx;
      end
    end
  end

  assign accept = (state == IDLE) && any_req;

  // State register; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: writes finish after ISSUE; reads need one more cycle for DOUT.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = ISSUE;
      ISSUE:   next_state = op_wr ? IDLE : RD_WAIT;
      RD_WAIT: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Remember who won and what kind of operation it is, for the later ISSUE and RD_WAIT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last   <= IW'(N_REQ - 1);
      op_win <= '0;
      op_wr  <= 1'b0;
    end else if (accept) begin
      last   <= win;
      op_win <= win;
      op_wr  <= bus.req_wr[win];
    end
  end

  // Output decode: compute what every output register should hold during the next cycle.
  always_comb begin
    gnt_d     = '0;
    rvalid_d  = '0;
    rf_wen_d  = 1'b0;
    rf_oen_d  = 1'b0;
    rf_addr_d = bus.rf_addr;
    rf_din_d  = bus.rf_din;
    rdata_d   = bus.rdata;
    busy_d    = (next_state != IDLE);
    if (accept) begin
      gnt_d[win] = 1'b1;
      rf_addr_d  = bus.req_addr[win*AW +: AW];
      if (bus.req_wr[win]) begin
        rf_wen_d = 1'b1;
        rf_din_d = bus.req_wdata[win*DW +: DW];
      end else begin
        rf_oen_d = 1'b1;
      end
    end
    if (state == RD_WAIT) begin
      rvalid_d[op_win] = 1'b1;
      rdata_d          = bus.rf_dout;
    end
  end

  // Output registers.
  // Asynchronous reset clears RF_WEN at once, so a write whose ISSUE cycle is cut short by reset never commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.gnt     <= '0;
      bus.rvalid  <= '0;
      bus.rdata   <= '0;
      bus.busy    <= 1'b0;
      bus.rf_wen  <= 1'b0;
      bus.rf_oen  <= 1'b0;
      bus.rf_addr <= '0;
      bus.rf_din  <= '0;
    end else begin
      bus.gnt     <= gnt_d;
      bus.rvalid  <= rvalid_d;
      bus.rdata   <= rdata_d;
      bus.busy    <= busy_d;
      bus.rf_wen  <= rf_wen_d;
      bus.rf_oen  <= rf_oen_d;
      bus.rf_addr <= rf_addr_d;
      bus.rf_din  <= rf_din_d;
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Testbench for regfile_arbiter.
// The bench provides two client queues and a behavioural 8x8 register file with a registered DOUT.
// A reference model predicts grants, register-file bus values, BUSY and read returns from the
// arbitration rules and a shadow copy of the register contents.
module tb_regfile_arbiter;

  localparam int N_REQ = 2;
  localparam int AW    = 3;
  localparam int DW    = 8;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  typedef struct {
    int            edge_at;
    int            id;
    logic [DW-1:0] data;
  } rd_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_arbiter_if #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) bus ();

  regfile_arbiter #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Behavioural register file: the write commits on the edge; DOUT is registered one cycle after OEN.
  logic [DW-1:0] rf_mem [8] = '{default: '0};
  always @(posedge clk) begin
    if (bus.rf_wen) rf_mem[bus.rf_addr] <= bus.rf_din;
    if (bus.rf_oen) bus.rf_dout <= rf_mem[bus.rf_addr];
  end

  // Client operation queues
  op_t opq [N_REQ][$];

  // Reference model state
  int            edge_n    = 0;
  int            ref_ready = 0;
  int            ref_last  = N_REQ - 1;
  logic [DW-1:0] ref_mem [8] = '{default: '0};
  logic [DW-1:0] ref_rdata = '0;
  rd_t           rvq[$];
  logic [N_REQ-1:0] exp_gnt = '0;
  logic          exp_wen = 1'b0;
  logic          exp_oen = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_din = '0;
  int            gnt_log[$];
  int            rv_log[$];
  int            rv_count = 0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int last_id, input logic [N_REQ-1:0] r);
    logic [N_REQ-1:0] rot;
    for (int step = 1; step <= N_REQ; step++) begin
      rot = r >> ((last_id + step) % N_REQ);
      if (rot[0]) return (last_id + step) % N_REQ;
    end
    return -1;
  endfunction

  // Reference model: on each edge, decide whether an operation is accepted and what it should produce.
  always @(posedge clk) begin
    int w;
    edge_n++;
    exp_gnt = '0;
    exp_wen = 1'b0;
    exp_oen = 1'b0;
    if (!rst_n) begin
      ref_last  = N_REQ - 1;
      ref_ready = edge_n;
      ref_rdata = '0;
      rvq.delete();
    end else if (edge_n >= ref_ready && bus.req != '0) begin
      w = rr_pick(ref_last, bus.req);
      ref_last   = w;
      exp_gnt[w] = 1'b1;
      exp_addr   = bus.req_addr[w*AW +: AW];
      if (bus.req_wr[w]) begin
        exp_wen = 1'b1;
        exp_din = bus.req_wdata[w*DW +: DW];
        ref_mem[exp_addr] = exp_din;
        ref_ready = edge_n + 2;
      end else begin
        exp_oen = 1'b1;
        rvq.push_back('{edge_at: edge_n, id: w, data: ref_mem[exp_addr]});
        ref_ready = edge_n + 3;
      end
    end
  end

  // Output checker: compare DUT outputs with the model mid-cycle, away from the active edge.
  always @(negedge clk) begin
    logic [N_REQ-1:0] exp_rv;
    if (!rst_n) begin
      check_output("rst_gnt", 32'(bus.gnt), 0);
      check_output("rst_rvalid", 32'(bus.rvalid), 0);
      check_output("rst_rdata", 32'(bus.rdata), 0);
      check_output("rst_busy", 32'(bus.busy), 0);
      check_output("rst_wen", 32'(bus.rf_wen), 0);
      check_output("rst_oen", 32'(bus.rf_oen), 0);
      check_output("rst_addr", 32'(bus.rf_addr), 0);
      check_output("rst_din", 32'(bus.rf_din), 0);
    end else begin
      check_output("gnt", 32'(bus.gnt), 32'(exp_gnt));
      check_output("rf_wen", 32'(bus.rf_wen), 32'(exp_wen));
      check_output("rf_oen", 32'(bus.rf_oen), 32'(exp_oen));
      check_output("busy", 32'(bus.busy), 32'(edge_n <= ref_ready - 2));
      if (exp_gnt != '0) begin
        check_output("rf_addr", 32'(bus.rf_addr), 32'(exp_addr));
        if (exp_wen) check_output("rf_din", 32'(bus.rf_din), 32'(exp_din));
      end
      exp_rv = '0;
      if (rvq.size() > 0 && rvq[0].edge_at + 2 == edge_n) begin
        exp_rv[rvq[0].id] = 1'b1;
        ref_rdata = rvq[0].data;
        void'(rvq.pop_front());
      end
      check_output("rvalid", 32'(bus.rvalid), 32'(exp_rv));
      check_output("rdata", 32'(bus.rdata), 32'(ref_rdata));
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (bus.gnt[i]) gnt_log.push_back(i);
      if (bus.rvalid[i]) begin
        rv_log.push_back(i);
        rv_count++;
      end
    end
  end

  task automatic push_op(input int id, input bit wr, input int addr, input int data);
    opq[id].push_back('{wr: wr, addr: AW'(addr), data: DW'(data)});
  endtask

  // Drive each client's head-of-queue operation onto its request lines.
  task automatic apply_stimulus();
    for (int i = 0; i < N_REQ; i++) begin
      if (opq[i].size() > 0) begin
        bus.req[i]                 = 1'b1;
        bus.req_wr[i]              = opq[i][0].wr;
        bus.req_addr[i*AW +: AW]   = opq[i][0].addr;
        bus.req_wdata[i*DW +: DW]  = opq[i][0].data;
      end else begin
        bus.req[i]                 = 1'b0;
        bus.req_wr[i]              = 1'b0;
        bus.req_addr[i*AW +: AW]   = '0;
        bus.req_wdata[i*DW +: DW]  = '0;
      end
    end
  endtask

  // One clock. A client that saw its GNT retires that operation on the edge that ends the GNT cycle.
  task automatic tick();
    logic [N_REQ-1:0] g;
    @(negedge clk);
    g = bus.gnt;
    @(posedge clk);
    #1;
    for (int i = 0; i < N_REQ; i++)
      if (g[i] && opq[i].size() > 0) void'(opq[i].pop_front());
    apply_stimulus();
  endtask

  function automatic bit ops_pending();
    for (int i = 0; i < N_REQ; i++)
      if (opq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input int budget, input string tag);
    int n = 0;
    while ((ops_pending() || rvq.size() > 0 || edge_n < ref_ready) && n < budget) begin
      tick();
      n++;
    end
    check_output({tag, "_timeout"}, 32'(n < budget), 1);
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int rv_before;
    bus.req       = '0;
    bus.req_wr    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // 1: reset with random requests, then release with both clients requesting
    repeat (4) begin
      @(posedge clk);
      #1;
      bus.req       = N_REQ'($urandom);
      bus.req_wr    = N_REQ'($urandom);
      bus.req_addr  = (N_REQ*AW)'($urandom);
      bus.req_wdata = (N_REQ*DW)'($urandom);
    end
    gnt_log.delete();
    push_op(0, 0, 1, 0);
    push_op(1, 0, 2, 0);
    apply_stimulus();
    rst_n = 1'b1;
    drain(50, "t1");
    check_output("t1_first_gnt", 32'(gnt_log[0]), 0);
    check_output("t1_second_gnt", 32'(gnt_log[1]), 1);

    // 3: two continuous readers alternate
    gnt_log.delete();
    for (int k = 0; k < 2; k++) begin
      push_op(0, 0, $urandom_range(0, 7), 0);
      push_op(1, 0, $urandom_range(0, 7), 0);
    end
    apply_stimulus();
    drain(100, "t3");
    check_output("t3_gnt_count", 32'(gnt_log.size()), 4);
    for (int k = 0; k < 4; k++)
      check_output("t3_gnt_order", 32'(gnt_log[k]), 32'(k % 2));

    // 2: write 0xA5 to addr 3, then read it back
    push_op(0, 1, 3, 8'hA5);
    apply_stimulus();
    drain(50, "t2w");
    push_op(0, 0, 3, 0);
    apply_stimulus();
    drain(50, "t2r");
    check_output("t2_rdata", 32'(bus.rdata), 32'h0A5);
    check_output("t2_rvalid_id", 32'(rv_log[$]), 0);

    // 4: read queued behind a write from the other client
    push_op(1, 1, 7, 8'h3C);
    apply_stimulus();
    tick();
    push_op(0, 0, 7, 0);
    apply_stimulus();
    drain(50, "t4");
    check_output("t4_rdata", 32'(bus.rdata), 32'h03C);
    check_output("t4_rvalid_id", 32'(rv_log[$]), 0);

    // 5: reset during RD_WAIT drops the read
    push_op(0, 1, 5, 8'h5A);
    apply_stimulus();
    drain(50, "t5w");
    push_op(0, 0, 5, 0);
    apply_stimulus();
    n = 0;
    while (opq[0].size() > 0 && n < 20) begin
      tick();
      n++;
    end
    check_output("t5_grant_timeout", 32'(n < 20), 1);
    rv_before = rv_count;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check_output("t5_no_rvalid", 32'(rv_count), 32'(rv_before));
    push_op(0, 0, 5, 0);
    apply_stimulus();
    drain(50, "t5r");
    check_output("t5_rdata", 32'(bus.rdata), 32'h05A);

    // 6: address extremes do not alias
    push_op(0, 1, 0, 8'h11);
    push_op(1, 1, 7, 8'hEE);
    apply_stimulus();
    drain(50, "t6w");
    push_op(0, 0, 0, 0);
    apply_stimulus();
    drain(50, "t6r0");
    check_output("t6_addr0", 32'(bus.rdata), 32'h011);
    push_op(1, 0, 7, 0);
    apply_stimulus();
    drain(50, "t6r7");
    check_output("t6_addr7", 32'(bus.rdata), 32'h0EE);

    // random mixed traffic from both clients
    for (int k = 0; k < 60; k++)
      push_op($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 255));
    apply_stimulus();
    drain(1000, "rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
